// File: rtl/instruction_ram_loader_if.sv
// Boot-load bus bundle: control from BIOS logic, HD read port, instruction-RAM write port.
// The loader is the master; the environment driving it (BIOS, memories) takes the slave side.
interface instruction_ram_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] hdBase;
    logic [ADDR_WIDTH-1:0] ramBase;
    logic [ADDR_WIDTH:0]   wordCount;
    logic [ADDR_WIDTH-1:0] hdAddress;
    logic                  hdRead;
    logic [DATA_WIDTH-1:0] hdData;
    logic [ADDR_WIDTH-1:0] iRAMAddress;
    logic [DATA_WIDTH-1:0] iRAMWriteData;
    logic                  iRAMWrite;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] checksum;

    modport master (
        input  start, hdBase, ramBase, wordCount, hdData,
        output hdAddress, hdRead, iRAMAddress, iRAMWriteData, iRAMWrite,
               busy, done, checksum
    );

    modport slave (
        output start, hdBase, ramBase, wordCount, hdData,
        input  hdAddress, hdRead, iRAMAddress, iRAMWriteData, iRAMWrite,
               busy, done, checksum
    );
endinterface

// File: rtl/instruction_ram_loader.sv
// Copies a block of HD words into instruction RAM (read, wait, write per word) with an XOR checksum.
// Every output is a register loaded from the next-state logic, so strobes line up with the state they belong to.
module instruction_ram_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input logic                    clock,
    input logic                    reset,
    instruction_ram_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] hd_base, hd_base_n;
    logic [ADDR_WIDTH-1:0] ram_base, ram_base_n;
    logic [ADDR_WIDTH:0]   count, count_n;
    logic [ADDR_WIDTH:0]   index, index_n;
    logic [ADDR_WIDTH-1:0] hd_addr, hd_addr_n;
    logic [ADDR_WIDTH-1:0] ram_addr, ram_addr_n;
    logic [DATA_WIDTH-1:0] wdata, wdata_n;
    logic [DATA_WIDTH-1:0] sum, sum_n;
    logic                  hd_read, hd_read_n;
    logic                  ram_write, ram_write_n;
    logic                  busy, busy_n;
    logic                  done, done_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hd_base   <= '0;
            ram_base  <= '0;
            count     <= '0;
            index     <= '0;
            hd_addr   <= '0;
            ram_addr  <= '0;
            wdata     <= '0;
            sum       <= '0;
            hd_read   <= 1'b0;
            ram_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            hd_base   <= hd_base_n;
            ram_base  <= ram_base_n;
            count     <= count_n;
            index     <= index_n;
            hd_addr   <= hd_addr_n;
            ram_addr  <= ram_addr_n;
            wdata     <= wdata_n;
            sum       <= sum_n;
            hd_read   <= hd_read_n;
            ram_write <= ram_write_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        hd_base_n   = hd_base;
        ram_base_n  = ram_base;
        count_n     = count;
        index_n     = index;
        hd_addr_n   = hd_addr;
        ram_addr_n  = ram_addr;
        wdata_n     = wdata;
        sum_n       = sum;
        hd_read_n   = 1'b0;
        ram_write_n = 1'b0;
        busy_n      = busy;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    hd_base_n  = bus.hdBase;
                    ram_base_n = bus.ramBase;
                    count_n    = bus.wordCount;
                    index_n    = '0;
                    sum_n      = '0;
                    busy_n     = 1'b1;
                    if (bus.wordCount == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n   = READ;
                        hd_read_n = 1'b1;
                        hd_addr_n = bus.hdBase;
                    end
                end
            end
            READ: state_n = WAIT;
            WAIT: begin
                // hdData is valid now, one cycle after the read strobe
                state_n     = WRITE;
                ram_write_n = 1'b1;
                ram_addr_n  = ram_base + index[ADDR_WIDTH-1:0];
                wdata_n     = bus.hdData;
            end
            WRITE: begin
                sum_n   = sum ^ wdata;
                index_n = index + (ADDR_WIDTH+1)'(1);
                if (index_n == count) begin
                    state_n = DONE;
                end else begin
                    state_n   = READ;
                    hd_read_n = 1'b1;
                    hd_addr_n = hd_base + index_n[ADDR_WIDTH-1:0];
                end
            end
            DONE: begin
                // done is registered, so it shows in the first IDLE cycle
                state_n = IDLE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.hdAddress     = hd_addr;
    assign bus.hdRead        = hd_read;
    assign bus.iRAMAddress   = ram_addr;
    assign bus.iRAMWriteData = wdata;
    assign bus.iRAMWrite     = ram_write;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.checksum      = sum;
endmodule
